// File: rtl/alu_exec.sv
// Two-stage integer ALU feeding an in-order result queue onto the CDB.
// Define ALU_BYPASS_EN to forward the stage register when the queue is empty.
module alu_exec #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        flag_alu,
  input  logic [5:0]  op_alu,
  input  logic [31:0] rs1_alu,
  input  logic [31:0] rs2_alu,
  input  logic [3:0]  rob_alu,
  input  logic        cdb_grant,
  output logic        alu_ans_flag,
  output logic [3:0]  alu_ans_reorder,
  output logic [31:0] alu_ans,
  output logic        alu_ans_taken,
  output logic        alu_stall,
  output logic        alu_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] STALL_TH = (CW+1)'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [31:0]   res_d;
  logic          tkn_d;
  logic [31:0]   sum;
  logic [4:0]    shamt;

  logic          stg_v_q;
  logic [31:0]   stg_ans_q;
  logic [3:0]    stg_tag_q;
  logic          stg_tkn_q;

  logic [31:0]   ans_q [FIFO_DEPTH];
  logic [3:0]    tag_q [FIFO_DEPTH];
  logic          tkn_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;

  logic          fifo_ne, full, byp, pop, byp_take;
  logic          push, stg_free, acc, drop;
  logic [CW:0]   occ;

  assign sum   = rs1_alu + rs2_alu;
  assign shamt = rs2_alu[4:0];

  always_comb begin
    res_d = '0;
    tkn_d = 1'b0;
    case (op_alu)
      6'd0:  res_d = sum;
      6'd1:  res_d = rs1_alu - rs2_alu;
      6'd2:  res_d = rs1_alu << shamt;
      6'd3:  res_d = {31'd0, $signed(rs1_alu) < $signed(rs2_alu)};
      6'd4:  res_d = {31'd0, rs1_alu < rs2_alu};
      6'd5:  res_d = rs1_alu ^ rs2_alu;
      6'd6:  res_d = rs1_alu >> shamt;
      6'd7:  res_d = $signed(rs1_alu) >>> shamt;
      6'd8:  res_d = rs1_alu | rs2_alu;
      6'd9:  res_d = rs1_alu & rs2_alu;
      6'd10: tkn_d = rs1_alu == rs2_alu;
      6'd11: tkn_d = rs1_alu != rs2_alu;
      6'd12: tkn_d = $signed(rs1_alu) < $signed(rs2_alu);
      6'd13: tkn_d = $signed(rs1_alu) >= $signed(rs2_alu);
      6'd14: tkn_d = rs1_alu < rs2_alu;
      6'd15: tkn_d = rs1_alu >= rs2_alu;
      6'd16: begin
        res_d = sum & ~32'd1;
        tkn_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign fifo_ne = cnt_q != '0;
  assign full    = cnt_q == FULL_CNT;
`ifdef ALU_BYPASS_EN
  assign byp     = !fifo_ne && stg_v_q;
`else
  assign byp     = 1'b0;
`endif
  assign pop      = fifo_ne && cdb_grant;
  assign byp_take = byp && cdb_grant;
  // Stage moves on when the queue has room or is draining this edge.
  assign push     = stg_v_q && !byp_take && (!full || pop);
  assign stg_free = !stg_v_q || byp_take || push;
  assign acc      = flag_alu && stg_free;
  assign drop     = flag_alu && !stg_free;
  assign occ      = {1'b0, cnt_q} + (CW+1)'(stg_v_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_v_q   <= 1'b0;
      stg_ans_q <= '0;
      stg_tag_q <= '0;
      stg_tkn_q <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        stg_v_q <= 1'b0;
        wp_q    <= '0;
        rp_q    <= '0;
        cnt_q   <= '0;
      end else begin
        stg_v_q <= acc || (stg_v_q && !stg_free);
        if (acc) begin
          stg_ans_q <= res_d;
          stg_tag_q <= rob_alu;
          stg_tkn_q <= tkn_d;
        end
        if (push) wp_q <= wp_q + 1'b1;
        if (pop)  rp_q <= rp_q + 1'b1;
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
        if (drop) ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush && push) begin
      ans_q[wp_q] <= stg_ans_q;
      tag_q[wp_q] <= stg_tag_q;
      tkn_q[wp_q] <= stg_tkn_q;
    end
  end

  always_comb begin
    alu_ans_flag    = fifo_ne || byp;
    alu_ans         = '0;
    alu_ans_reorder = '0;
    alu_ans_taken   = 1'b0;
    if (byp) begin
      alu_ans         = stg_ans_q;
      alu_ans_reorder = stg_tag_q;
      alu_ans_taken   = stg_tkn_q;
    end else if (fifo_ne) begin
      alu_ans         = ans_q[rp_q];
      alu_ans_reorder = tag_q[rp_q];
      alu_ans_taken   = tkn_q[rp_q];
    end
  end

  assign alu_stall = occ >= STALL_TH;
  assign alu_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed vector bench for alu_exec: opcode table plus queue,
// flush, freeze and overflow sequences.
module tb_alu_exec;

`ifdef ALU_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 0;
  logic        rst, rdy, flush, flag_alu, cdb_grant;
  logic [5:0]  op_alu;
  logic [31:0] rs1_alu, rs2_alu;
  logic [3:0]  rob_alu;
  logic        alu_ans_flag, alu_ans_taken, alu_stall, alu_ovf;
  logic [3:0]  alu_ans_reorder;
  logic [31:0] alu_ans;

  int total = 0;
  int bad   = 0;

  alu_exec #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .flag_alu(flag_alu), .op_alu(op_alu),
    .rs1_alu(rs1_alu), .rs2_alu(rs2_alu),
    .rob_alu(rob_alu), .cdb_grant(cdb_grant),
    .alu_ans_flag(alu_ans_flag),
    .alu_ans_reorder(alu_ans_reorder),
    .alu_ans(alu_ans), .alu_ans_taken(alu_ans_taken),
    .alu_stall(alu_stall), .alu_ovf(alu_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] ans;
    logic        tkn;
  } vec_t;

  vec_t v [18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic run_vec(input int idx);
    int lat;
    bit found;
    @(negedge clk);
    op_alu = v[idx].op; rs1_alu = v[idx].a; rs2_alu = v[idx].b;
    rob_alu = v[idx].tag; flag_alu = 1; cdb_grant = 1;
    @(posedge clk);
    #1 flag_alu = 0;
    lat = 0; found = 0;
    for (int k = 1; k <= 4 && !found; k++) begin
      @(negedge clk);
      if (alu_ans_flag) begin
        found = 1;
        lat = k;
        chk($sformatf("v%0d ans", idx), alu_ans, v[idx].ans);
        chk($sformatf("v%0d tag", idx), 32'(alu_ans_reorder), 32'(v[idx].tag));
        chk($sformatf("v%0d taken", idx), 32'(alu_ans_taken), 32'(v[idx].tkn));
      end
    end
    chk($sformatf("v%0d latency", idx), lat, LAT);
    @(negedge clk);
    chk($sformatf("v%0d pulse", idx), 32'(alu_ans_flag), 0);
  endtask

  initial begin
    v[0]  = '{6'd0,  32'd5,          32'd7,          4'd3, 32'd12,         1'b0};
    v[1]  = '{6'd1,  32'd5,          32'd7,          4'd1, 32'hFFFFFFFE,   1'b0};
    v[2]  = '{6'd2,  32'd1,          32'h21,         4'd2, 32'd2,          1'b0};
    v[3]  = '{6'd3,  32'hFFFFFFFF,   32'd1,          4'd4, 32'd1,          1'b0};
    v[4]  = '{6'd4,  32'd1,          32'hFFFFFFFF,   4'd5, 32'd1,          1'b0};
    v[5]  = '{6'd5,  32'hF0F0F0F0,   32'hFF00FF00,   4'd6, 32'h0FF00FF0,   1'b0};
    v[6]  = '{6'd6,  32'h80000000,   32'h24,         4'd7, 32'h08000000,   1'b0};
    v[7]  = '{6'd7,  32'h80000000,   32'h24,         4'd8, 32'hF8000000,   1'b0};
    v[8]  = '{6'd8,  32'hF0F0F0F0,   32'h0000FFFF,   4'd9, 32'hF0F0FFFF,   1'b0};
    v[9]  = '{6'd9,  32'hF0F0F0F0,   32'h0000FFFF,   4'd10, 32'h0000F0F0,  1'b0};
    v[10] = '{6'd10, 32'd42,         32'd42,         4'd11, 32'd0,         1'b1};
    v[11] = '{6'd11, 32'd42,         32'd42,         4'd12, 32'd0,         1'b0};
    v[12] = '{6'd12, 32'hFFFFFFFF,   32'd1,          4'd13, 32'd0,         1'b1};
    v[13] = '{6'd13, 32'hFFFFFFFF,   32'd1,          4'd14, 32'd0,         1'b0};
    v[14] = '{6'd14, 32'd1,          32'hFFFFFFFF,   4'd15, 32'd0,         1'b1};
    v[15] = '{6'd15, 32'hFFFFFFFF,   32'd1,          4'd0, 32'd0,          1'b1};
    v[16] = '{6'd16, 32'h1001,       32'd4,          4'd9, 32'h1004,       1'b1};
    v[17] = '{6'd20, 32'd9,          32'd9,          4'd2, 32'd0,          1'b0};

    rst = 1; rdy = 1; flush = 0; flag_alu = 0; cdb_grant = 0;
    op_alu = 0; rs1_alu = 0; rs2_alu = 0; rob_alu = 0;
    do_reset();
    @(negedge clk);
    chk("rst flag", 32'(alu_ans_flag), 0);
    chk("rst ans", alu_ans, 0);
    chk("rst tag", 32'(alu_ans_reorder), 0);
    chk("rst taken", 32'(alu_ans_taken), 0);
    chk("rst stall", 32'(alu_stall), 0);
    chk("rst ovf", 32'(alu_ovf), 0);

    for (int i = 0; i < 18; i++) run_vec(i);

    // Fill queue with grant low; tag 5 must be dropped.
    @(negedge clk);
    cdb_grant = 0;
    op_alu = 6'd0; rs2_alu = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("fill stall %0d", i), 32'(alu_stall), 32'(i >= 3));
      if (i == 5) chk("ovf before drop", 32'(alu_ovf), 0);
      rs1_alu = 32'(100 + i); rob_alu = 4'(i); flag_alu = 1;
      @(posedge clk);
    end
    #1 flag_alu = 0;
    @(negedge clk);
    chk("ovf set", 32'(alu_ovf), 1);
    chk("full stall", 32'(alu_stall), 1);
    cdb_grant = 1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain flag %0d", i), 32'(alu_ans_flag), 1);
      chk($sformatf("drain tag %0d", i), 32'(alu_ans_reorder), i);
      chk($sformatf("drain ans %0d", i), alu_ans, 32'(100 + i));
      @(negedge clk);
    end
    chk("drain empty", 32'(alu_ans_flag), 0);
    chk("ovf sticky", 32'(alu_ovf), 1);
    do_reset();
    @(negedge clk);
    chk("ovf cleared", 32'(alu_ovf), 0);

    // Flush with two queued results and concurrent dispatch/grant.
    cdb_grant = 0;
    op_alu = 6'd0; rs1_alu = 1; rs2_alu = 1;
    rob_alu = 4'd1; flag_alu = 1;
    @(posedge clk);
    #1 rob_alu = 4'd2;
    @(posedge clk);
    #1 flag_alu = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre-flush flag", 32'(alu_ans_flag), 1);
    flush = 1; flag_alu = 1; cdb_grant = 1; rob_alu = 4'd6;
    @(posedge clk);
    #1 flush = 0; flag_alu = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post-flush flag %0d", k), 32'(alu_ans_flag), 0);
    end
    chk("post-flush stall", 32'(alu_stall), 0);

    // Freeze with a result at the head and grant asserted.
    cdb_grant = 0;
    op_alu = 6'd5; rs1_alu = 32'hA5; rs2_alu = 32'h0F;
    rob_alu = 4'd7; flag_alu = 1;
    @(posedge clk);
    #1 flag_alu = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rdy = 0; cdb_grant = 1; flag_alu = 1; flush = 1; rob_alu = 4'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("frz flag %0d", k), 32'(alu_ans_flag), 1);
      chk($sformatf("frz tag %0d", k), 32'(alu_ans_reorder), 7);
      chk($sformatf("frz ans %0d", k), alu_ans, 32'hAA);
    end
    flag_alu = 0; flush = 0; rdy = 1;
    @(negedge clk);
    chk("unfreeze pop", 32'(alu_ans_flag), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
